// File: rtl/instruction_sequencer.sv
// Eight-phase instruction sequencer for a simple accumulator CPU: a phase counter
// with a sticky halt flag and a Moore-style control-strobe decode.

package instruction_sequencer_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
    XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
  } opcode_t;
  typedef logic [2:0] state_t;
endpackage

module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 8
) (
  input  logic    clk,
  input  logic    rst_,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    sel,
  output logic    rd,
  output logic    wr,
  output logic    ld_ir,
  output logic    ld_ac,
  output logic    inc_pc,
  output logic    ld_pc,
  output logic    data_e,
  output logic    halt,
  output state_t  phase
);

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;
  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

  logic [2:0] phase_r;
  logic       halted_r;
  logic       aluop_s;

  // Phase counter and sticky halt flag; once halted only rst_ releases the sequencer.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_r  <= INST_ADDR;
      halted_r <= 1'b0;
    end else if (halted_r) begin
      phase_r  <= phase_r;
      halted_r <= 1'b1;
    end else if ((phase_r == OP_ADDR) && (opcode == HLT)) begin
      phase_r  <= phase_r;
      halted_r <= 1'b1;
    end else begin
      phase_r  <= (phase_r == LAST_PHASE) ? INST_ADDR : phase_r + 3'd1;
      halted_r <= 1'b0;
    end
  end

  // ALU-class opcodes read an operand and load the accumulator.
  always_comb begin
    aluop_s = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);
  end

  // Strobe decode from the registered phase; halted state overrides every phase.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_r) begin
      halt = 1'b1;
    end else begin
      case (phase_r)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = aluop_s;
        end
        ALU_OP: begin
          rd     = aluop_s;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop_s;
          ld_ac  = aluop_s;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: table of back-to-back instructions
// plus hand sequences for halt and mid-instruction reset.

module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  logic    clk;
  logic    rst_;
  opcode_t opcode;
  logic    zero;
  logic    sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  state_t  phase;

  int checks;
  int errors;

  instruction_sequencer #(.NUM_PHASES(8)) dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .data_e(data_e), .halt(halt),
    .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle order: sel rd wr ld_ir ld_ac inc_pc ld_pc data_e halt
  localparam logic [8:0] O_IADDR  = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_IFETCH = 9'b1_1_0_0_0_0_0_0_0;
  localparam logic [8:0] O_ILOAD  = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] O_OPADDR = 9'b0_0_0_0_0_1_0_0_0;
  localparam logic [8:0] O_NONE   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_RD     = 9'b0_1_0_0_0_0_0_0_0;
  localparam logic [8:0] O_RDLDAC = 9'b0_1_0_0_1_0_0_0_0;
  localparam logic [8:0] O_INC    = 9'b0_0_0_0_0_1_0_0_0;
  localparam logic [8:0] O_DE     = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] O_WRDE   = 9'b0_0_1_0_0_0_0_1_0;
  localparam logic [8:0] O_LDPC   = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] O_HLTAD  = 9'b0_0_0_0_0_1_0_0_1;
  localparam logic [8:0] O_HALTED = 9'b0_0_0_0_0_0_0_0_1;

  typedef struct {
    opcode_t    op;
    logic       zero;
    logic [8:0] e_fetch;
    logic [8:0] e_alu;
    logic [8:0] e_store;
    int         incs;
  } vec_t;

  function automatic logic [8:0] outs();
    return {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  vec_t       vecs[8];
  logic [8:0] pre_exp[4];
  logic [8:0] exp_o;
  int         inc_cnt;
  int         wr_seen;

  initial begin
    checks  = 0;
    errors  = 0;
    pre_exp[0] = O_IADDR;
    pre_exp[1] = O_IFETCH;
    pre_exp[2] = O_ILOAD;
    pre_exp[3] = O_ILOAD;
    vecs[0] = '{ADD, 1'b0, O_RD,   O_RD,   O_RDLDAC, 1};
    vecs[1] = '{SKZ, 1'b1, O_NONE, O_INC,  O_NONE,   2};
    vecs[2] = '{SKZ, 1'b0, O_NONE, O_NONE, O_NONE,   1};
    vecs[3] = '{STO, 1'b0, O_NONE, O_DE,   O_WRDE,   1};
    vecs[4] = '{JMP, 1'b1, O_NONE, O_LDPC, O_LDPC,   1};
    vecs[5] = '{AND, 1'b1, O_RD,   O_RD,   O_RDLDAC, 1};
    vecs[6] = '{LDA, 1'b0, O_RD,   O_RD,   O_RDLDAC, 1};
    vecs[7] = '{XOR, 1'b1, O_RD,   O_RD,   O_RDLDAC, 1};

    // Reset state, asynchronous before any clock edge
    rst_   = 1'b0;
    opcode = HLT;
    zero   = 1'b0;
    #2;
    check("reset_phase", 9'(phase), 9'd0);
    check("reset_outs", outs(), O_IADDR);
    tick();
    tick();
    check("reset_hold_phase", 9'(phase), 9'd0);
    #5;
    rst_ = 1'b1;
    tick();
    check("release_first_phase", 9'(phase), 9'd1);
    // Realign to INST_ADDR: walk the remaining 7 phases of this instruction with a harmless opcode
    opcode = ADD;
    for (int p = 1; p < 8; p++) tick();
    check("realign_phase", 9'(phase), 9'd0);

    // Back-to-back instructions; opcode/zero carry junk outside their used phases
    for (int v = 0; v < 8; v++) begin
      inc_cnt = 0;
      for (int p = 0; p < 8; p++) begin
        opcode = (p < 3) ? HLT : vecs[v].op;
        zero   = (p == 6) ? vecs[v].zero : ~vecs[v].zero;
        #1;
        case (p)
          0, 1, 2, 3: exp_o = pre_exp[p];
          4:          exp_o = O_OPADDR;
          5:          exp_o = vecs[v].e_fetch;
          6:          exp_o = vecs[v].e_alu;
          default:    exp_o = vecs[v].e_store;
        endcase
        check($sformatf("vec%0d_p%0d_phase", v, p), 9'(phase), 9'(p));
        check($sformatf("vec%0d_p%0d_outs", v, p), outs(), exp_o);
        if (inc_pc === 1'b1) inc_cnt++;
        tick();
      end
      check($sformatf("vec%0d_inc_pulses", v), 9'(inc_cnt), 9'(vecs[v].incs));
    end
    check("no_bubble_phase", 9'(phase), 9'd0);

    // HLT: halt asserted in OP_ADDR, then frozen for 20 clocks
    opcode = HLT;
    for (int p = 0; p < 4; p++) tick();
    check("hlt_opaddr_phase", 9'(phase), 9'd4);
    check("hlt_opaddr_outs", outs(), O_HLTAD);
    inc_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      opcode = (c % 2 == 0) ? JMP : SKZ;
      zero   = 1'b1;
      #1;
      if (phase !== 3'd4 || outs() !== O_HALTED) inc_cnt++;
    end
    check("hlt_frozen_bad_cycles", 9'(inc_cnt), 9'd0);
    check("hlt_frozen_outs", outs(), O_HALTED);
    #1;
    rst_ = 1'b0;
    #1;
    check("hlt_async_reset_phase", 9'(phase), 9'd0);
    check("hlt_async_reset_outs", outs(), O_IADDR);
    tick();
    rst_ = 1'b1;
    tick();
    check("hlt_restart_phase", 9'(phase), 9'd1);

    // STO aborted by a reset pulse between edges in ALU_OP
    opcode = STO;
    zero   = 1'b0;
    for (int p = 1; p < 8; p++) tick();
    for (int p = 0; p < 6; p++) tick();
    check("sto_aluop_phase", 9'(phase), 9'd6);
    check("sto_aluop_outs", outs(), O_DE);
    rst_ = 1'b0;
    #1;
    check("sto_abort_phase", 9'(phase), 9'd0);
    check("sto_abort_outs", outs(), O_IADDR);
    #2;
    rst_ = 1'b1;
    wr_seen = 0;
    for (int c = 0; c < 7; c++) begin
      if (wr === 1'b1) wr_seen++;
      tick();
    end
    check("sto_abort_no_wr", 9'(wr_seen), 9'd0);
    check("sto_restart_phase", 9'(phase), 9'd7);
    check("sto_restart_store_outs", outs(), O_WRDE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter: NUM_PHASES, default 8, number of instruction-cycle phases; fixed at 8, other values unsupported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_  input  1  asynchronous, active-low reset.
REQ-004 Port: opcode  input  opcode_t (3)  from instruction register (typedefs); HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP = 0..7.
REQ-005 Port: zero  input  1  accumulator-zero flag, used only for SKZ.
REQ-006 Port: sel  output  1  address-mux select; 1 = PC address (drives mux sel_a=S1), 0 = IR operand address.
REQ-007 Port: rd  output  1  memory read enable.
REQ-008 Port: wr  output  1  memory write strobe.
REQ-009 Port: ld_ir  output  1  instruction-register load.
REQ-010 Port: ld_ac  output  1  accumulator load.
REQ-011 Port: inc_pc  output  1  program-counter increment.
REQ-012 Port: ld_pc  output  1  program-counter load (jump).
REQ-013 Port: data_e  output  1  data-bus drive enable for store.
REQ-014 Port: halt  output  1  processor halted indication.
REQ-015 Port: phase  output  state_t (3)  current phase, for debug/trace.

Function
REQ-016 Phase register SHALL advance INST_ADDR->INST_FETCH->INST_LOAD->IDLE->OP_ADDR->OP_FETCH->ALU_OP->STORE->INST_ADDR, one phase per clk, unless halted.
REQ-017 Outputs SHALL be combinational decode of registered phase, opcode, zero and halted flag only (Moore-style per phase; no output depends on other inputs).
REQ-018 ALUOP SHALL mean opcode in {ADD,AND,XOR,LDA}.
REQ-019 INST_ADDR: sel=1; all other strobes 0.
REQ-020 INST_FETCH: sel=1, rd=1.
REQ-021 INST_LOAD and IDLE: sel=1, rd=1, ld_ir=1.
REQ-022 OP_ADDR: sel=0, inc_pc=1, halt=1 if opcode==HLT.
REQ-023 OP_FETCH: sel=0, rd=ALUOP.
REQ-024 ALU_OP: sel=0, rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO).
REQ-025 STORE: sel=0, rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO), data_e=(opcode==STO).
REQ-026 Unlisted outputs in each phase SHALL be 0; no X on any output after reset.
REQ-027 On clk edge in OP_ADDR with opcode==HLT, sticky halted flag SHALL set; phase SHALL then hold OP_ADDR.
REQ-028 While halted: halt=1, sel=0, all other strobes 0 (inc_pc suppressed); only rst_ clears it.
REQ-029 opcode/zero changes outside their used phases SHALL have no effect on state.
REQ-030 Complete instruction SHALL take exactly 8 clocks; next INST_ADDR follows STORE with no bubble.
REQ-031 SKZ with zero=0 and all non-branch opcodes SHALL yield exactly one inc_pc pulse per instruction; SKZ with zero=1 exactly two.

Reset
REQ-032 rst_ low SHALL immediately (no clk) force phase=INST_ADDR, halted=0, hence sel=1 and all other outputs 0.
REQ-033 Release of rst_ SHALL be honoured on next clk edge; first edge after release moves to INST_FETCH.
REQ-034 Reset asserted mid-instruction (any phase, halted or not) SHALL abort the instruction with no further strobes.

Verification
REQ-035 Reset then 8 clks, opcode=ADD: per-phase outputs match REQ-019..025; ld_ac=1 only in STORE; phase back at INST_ADDR on clk 8.
REQ-036 opcode=SKZ, zero=1: inc_pc high in OP_ADDR and ALU_OP (2 pulses); zero=0: 1 pulse.
REQ-037 opcode=STO: data_e=1 in ALU_OP and STORE, wr=1 only in STORE, rd=0 in OP_FETCH..STORE.
REQ-038 opcode=JMP: ld_pc=1 in ALU_OP and STORE, rd=0, ld_ac=0.
REQ-039 opcode=HLT: halt=1 in OP_ADDR, phase frozen at OP_ADDR for 20 clks with inc_pc=0; rst_ low returns phase=INST_ADDR, halt=0 asynchronously.
REQ-040 rst_ pulsed low between edges during ALU_OP with opcode=STO: data_e drops immediately, wr never asserts, sequence restarts at INST_ADDR.
